// File: rtl/fsbm_pkg.sv
// Shared types for the full-search block-matching engine: data widths, sequencer states
// and the {mad, mvx, mvy} result record used by the compare unit and the top.
package fsbm_pkg;

  localparam int SAD_W = 12;
  localparam int MV_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_COMPARE,
    ST_WAIT_CMP,
    ST_DONE
  } fsbm_state_e;

  typedef struct packed {
    logic [SAD_W-1:0] mad;
    logic [MV_W-1:0]  mvx;
    logic [MV_W-1:0]  mvy;
  } fsbm_result_t;

endpackage

// File: rtl/fsbm_best_track.sv
// Global-best tracker: keeps the lowest row winner seen so far and presents it as the
// search result while the sequencer is in DONE.
module fsbm_best_track
  import fsbm_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         upd,
  input  fsbm_result_t cand,
  input  logic         res_en,
  output fsbm_result_t res
);

  fsbm_result_t best;

  // Strict less-than: on equal SAD the earlier row is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best <= '{mad: '1, mvx: '0, mvy: '0};
    end else if (init) begin
      best <= '{mad: '1, mvx: '0, mvy: '0};
    end else if (upd && (cand.mad < best.mad)) begin
      best <= cand;
    end
  end

  assign res = res_en ? best : '0;

endmodule

// File: rtl/fsbm_search_ctrl.sv
// Search sequencer: for one block it walks NUM_ROWS candidate rows (clear, accumulate,
// compare, wait), folds row winners into a global best and hands {mad, mvx, mvy} out.
module fsbm_search_ctrl
  import fsbm_pkg::*;
#(
  parameter int NUM_ROWS   = 16,
  parameter int ACC_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          pe_clear,
  output logic                          pe_acc_en,
  output logic [$clog2(ACC_CYCLES)-1:0] pix_line,
  output logic                          cmp_enable,
  output logic [MV_W-1:0]               cmp_row,
  input  logic                          cmp_valid,
  input  logic [SAD_W-1:0]              cmp_mad,
  input  logic [MV_W-1:0]               cmp_mvx,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [SAD_W-1:0]              res_mad,
  output logic [MV_W-1:0]               res_mvx,
  output logic [MV_W-1:0]               res_mvy
);

  localparam int PIX_W = $clog2(ACC_CYCLES);

  fsbm_state_e      state, state_nxt;
  logic [MV_W-1:0]  row, row_nxt;
  logic [PIX_W-1:0] pix_nxt;
  logic             best_init, best_upd;
  fsbm_result_t     cand, result;

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    pix_nxt   = pix_line;
    best_init = 1'b0;
    best_upd  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_CLEAR;
          row_nxt   = '0;
          best_init = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_nxt = ST_ACCUM;
        pix_nxt   = '0;
      end
      ST_ACCUM: begin
        if (pix_line == PIX_W'(ACC_CYCLES - 1)) begin
          state_nxt = ST_COMPARE;
          pix_nxt   = '0;
        end else begin
          pix_nxt = pix_line + PIX_W'(1);
        end
      end
      ST_COMPARE: state_nxt = ST_WAIT_CMP;
      ST_WAIT_CMP: begin
        if (cmp_valid) begin
          best_upd = 1'b1;
          if (row == MV_W'(NUM_ROWS - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            row_nxt   = row + MV_W'(1);
            state_nxt = ST_CLEAR;
          end
        end
      end
      ST_DONE: begin
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      row        <= '0;
      pix_line   <= '0;
      busy       <= 1'b0;
      pe_clear   <= 1'b0;
      pe_acc_en  <= 1'b0;
      cmp_enable <= 1'b0;
      cmp_row    <= '0;
      res_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      pix_line   <= pix_nxt;
      busy       <= (state_nxt != ST_IDLE);
      pe_clear   <= (state_nxt == ST_CLEAR);
      pe_acc_en  <= (state_nxt == ST_ACCUM);
      cmp_enable <= (state_nxt == ST_COMPARE);
      cmp_row    <= (state_nxt inside {ST_CLEAR, ST_ACCUM, ST_COMPARE, ST_WAIT_CMP}) ? row_nxt : '0;
      res_valid  <= (state_nxt == ST_DONE);
    end
  end

  assign cand = {cmp_mad, cmp_mvx, row};

  fsbm_best_track u_best (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (best_init),
    .upd    (best_upd),
    .cand   (cand),
    .res_en (res_valid),
    .res    (result)
  );

  assign res_mad = result.mad;
  assign res_mvx = result.mvx;
  assign res_mvy = result.mvy;

endmodule

// File: tb/tb_fsbm_search_ctrl.sv
// Bench for fsbm_search_ctrl: plays the compare unit from per-row response tables and
// checks the result and timing against a row-by-row reference computed from the tables.
module tb_fsbm_search_ctrl;

  localparam int NROWS = 16;
  localparam int ACC   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cmp_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [11:0] cmp_mad = '0;
  logic [3:0]  cmp_mvx = '0;
  logic        busy, pe_clear, pe_acc_en, cmp_enable, res_valid;
  logic [3:0]  pix_line, cmp_row, res_mvx, res_mvy;
  logic [11:0] res_mad;
  logic [32:0] outs;

  int checks = 0;
  int errors = 0;
  int mad_tab[NROWS];
  int mvx_tab[NROWS];
  int w_tab[NROWS];
  int got_cyc, got_mad, got_mvx, got_mvy;
  int clears, accs, pix_err, row_err, hold_err, post_err;

  fsbm_search_ctrl #(.NUM_ROWS(NROWS), .ACC_CYCLES(ACC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .pe_clear   (pe_clear),
    .pe_acc_en  (pe_acc_en),
    .pix_line   (pix_line),
    .cmp_enable (cmp_enable),
    .cmp_row    (cmp_row),
    .cmp_valid  (cmp_valid),
    .cmp_mad    (cmp_mad),
    .cmp_mvx    (cmp_mvx),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_mad    (res_mad),
    .res_mvx    (res_mvx),
    .res_mvy    (res_mvy)
  );

  assign outs = {busy, pe_clear, pe_acc_en, cmp_enable, res_valid,
                 pix_line, cmp_row, res_mad, res_mvx, res_mvy};

  always #5 clk = ~clk;

  // Reference: fold row winners with strict less-than; each row costs clear+accum+compare+wait.
  function automatic void model(output int mad, output int mvx, output int mvy, output int cyc);
    mad = 4095; mvx = 0; mvy = 0; cyc = 0;
    for (int r = 0; r < NROWS; r++) begin
      if (mad_tab[r] < mad) begin
        mad = mad_tab[r]; mvx = mvx_tab[r]; mvy = r;
      end
      cyc += 1 + ACC + 1 + w_tab[r];
    end
  endfunction

  // mode 0: mad=100-row, mvx=row; 1: random small mads; 2: all 50; 3: all-ones
  task automatic fill(input int mode, input int w);
    for (int r = 0; r < NROWS; r++) begin
      case (mode)
        0:       begin mad_tab[r] = 100 - r; mvx_tab[r] = r; end
        1:       begin mad_tab[r] = int'($urandom_range(0, 40)); mvx_tab[r] = int'($urandom_range(0, 15)); end
        2:       begin mad_tab[r] = 50; mvx_tab[r] = int'($urandom_range(0, 15)); end
        default: begin mad_tab[r] = 4095; mvx_tab[r] = int'($urandom_range(1, 15)); end
      endcase
      w_tab[r] = (w == 0) ? int'($urandom_range(1, 4)) : w;
    end
  endtask

  // Starts a search, answers compare requests from the tables, collects observations.
  task automatic run_search(input int abort_row, input int hold, input bit strays, input bit start_in_done);
    int n, k, cur_row, cnt;
    bit pend, done;
    logic [11:0] h_mad;
    logic [3:0] h_mvx, h_mvy;
    clears = 0; accs = 0; pix_err = 0; row_err = 0; hold_err = 0; post_err = 0;
    got_cyc = -1; got_mad = -1; got_mvx = -1; got_mvy = -1;
    n = 0; k = 0; cur_row = 0; cnt = 0; pend = 0; done = 0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (!done && n < 3000) begin
      cmp_valid = 1'b0;
      start = 1'b0;
      if (pe_clear) begin
        if (cmp_row !== 4'(clears)) row_err++;
        cur_row = clears; clears++; k = 0;
      end
      if (pe_acc_en) begin
        if (pix_line !== 4'(k)) pix_err++;
        k++; accs++;
        if (cur_row == abort_row && k == 3) return;
      end else if (pix_line !== 4'd0) pix_err++;
      if (busy && !res_valid && cmp_row !== 4'(cur_row)) row_err++;
      if (cmp_enable) begin
        pend = 1'b1; cnt = w_tab[cur_row] - 1;
      end else if (pend) begin
        if (cnt == 0) begin
          cmp_valid = 1'b1;
          cmp_mad = 12'(mad_tab[cur_row]);
          cmp_mvx = 4'(mvx_tab[cur_row]);
          pend = 1'b0;
        end else cnt--;
      end else if (strays && pe_acc_en && $urandom_range(0, 2) == 0) begin
        cmp_valid = 1'b1; cmp_mad = 12'd0; cmp_mvx = 4'($urandom_range(0, 15));
      end
      if (strays && busy && $urandom_range(0, 3) == 0) start = 1'b1;
      if (res_valid) done = 1'b1;
      else begin
        @(posedge clk); #1; n++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL search_timeout cycles=%0d limit=3000", n);
      cmp_valid = 1'b0; start = 1'b0;
      return;
    end
    got_cyc = n; got_mad = int'(res_mad); got_mvx = int'(res_mvx); got_mvy = int'(res_mvy);
    h_mad = res_mad; h_mvx = res_mvx; h_mvy = res_mvy;
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0; cmp_valid = 1'b0;
      start = strays ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      if (!res_valid || !busy || res_mad !== h_mad || res_mvx !== h_mvx || res_mvy !== h_mvy) hold_err++;
    end
    res_ready = 1'b1; start = start_in_done; cmp_valid = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b0; start = 1'b0;
    if (res_valid || busy || pe_clear || cmp_enable) post_err++;
    @(posedge clk); #1;
    if (busy) post_err++;
  endtask

  task automatic test_reset();
    int em, ex, ey, ec;
    rst_n = 1'b0; #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_init outs=%h expected 0", outs); end
    #20; @(negedge clk); rst_n = 1'b1;
    fill(1, 1);
    run_search(5, 0, 1'b0, 1'b0);
    checks++;
    if (clears != 6 || !pe_acc_en) begin
      errors++; $display("FAIL reset_reach_row5 clears=%0d acc_en=%b expected 6/1", clears, pe_acc_en);
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_async outs=%h expected 0", outs); end
    @(negedge clk); rst_n = 1'b1;
    fill(0, 1);
    run_search(-1, 0, 1'b0, 1'b0);
    model(em, ex, ey, ec);
    checks++;
    if (got_cyc != ec || got_cyc != 304) begin errors++; $display("FAIL reset_restart_cycles got=%0d expected %0d", got_cyc, ec); end
    checks++;
    if (got_mad != em || got_mvx != ex || got_mvy != ey) begin
      errors++; $display("FAIL reset_restart_res got=%0d/%0d/%0d expected %0d/%0d/%0d", got_mad, got_mvx, got_mvy, em, ex, ey);
    end
  endtask

  task automatic test_descending();
    fill(0, 1);
    run_search(-1, 0, 1'b0, 1'b0);
    checks++;
    if (got_cyc != 304) begin errors++; $display("FAIL desc_cycles got=%0d expected 304", got_cyc); end
    checks++;
    if (got_mad != 85 || got_mvx != 15 || got_mvy != 15) begin
      errors++; $display("FAIL desc_res got=%0d/%0d/%0d expected 85/15/15", got_mad, got_mvx, got_mvy);
    end
    checks++;
    if (post_err != 0) begin errors++; $display("FAIL desc_handshake errs=%0d expected 0", post_err); end
  endtask

  task automatic test_tie();
    fill(2, 1);
    mad_tab[3] = 7; mvx_tab[3] = 9;
    mad_tab[11] = 7; mvx_tab[11] = 4;
    run_search(-1, 0, 1'b0, 1'b0);
    checks++;
    if (got_mad != 7 || got_mvx != 9 || got_mvy != 3) begin
      errors++; $display("FAIL tie_res got=%0d/%0d/%0d expected 7/9/3", got_mad, got_mvx, got_mvy);
    end
  endtask

  task automatic test_all_ones();
    fill(3, 1);
    run_search(-1, 0, 1'b0, 1'b0);
    checks++;
    if (got_mad != 4095 || got_mvx != 0 || got_mvy != 0) begin
      errors++; $display("FAIL allones_res got=%0d/%0d/%0d expected 4095/0/0", got_mad, got_mvx, got_mvy);
    end
  endtask

  task automatic test_delay_strays();
    int em, ex, ey, ec;
    fill(0, 5);
    run_search(-1, 0, 1'b1, 1'b0);
    model(em, ex, ey, ec);
    checks++;
    if (got_cyc != 368) begin errors++; $display("FAIL delay_cycles got=%0d expected 368", got_cyc); end
    checks++;
    if (got_mad != em || got_mvx != ex || got_mvy != ey) begin
      errors++; $display("FAIL delay_res got=%0d/%0d/%0d expected %0d/%0d/%0d", got_mad, got_mvx, got_mvy, em, ex, ey);
    end
  endtask

  task automatic test_ready_hold();
    int em, ex, ey, ec;
    fill(1, 1);
    run_search(-1, 10, 1'b1, 1'b1);
    model(em, ex, ey, ec);
    checks++;
    if (hold_err != 0) begin errors++; $display("FAIL hold_stable errs=%0d expected 0", hold_err); end
    checks++;
    if (post_err != 0) begin errors++; $display("FAIL hold_start_dropped errs=%0d expected 0", post_err); end
    checks++;
    if (got_cyc != ec || got_mad != em || got_mvx != ex || got_mvy != ey) begin
      errors++; $display("FAIL hold_res got=%0d/%0d/%0d@%0d expected %0d/%0d/%0d@%0d",
                         got_mad, got_mvx, got_mvy, got_cyc, em, ex, ey, ec);
    end
  endtask

  task automatic test_protocol();
    fill(1, 0);
    run_search(-1, 0, 1'b1, 1'b0);
    checks++;
    if (clears != NROWS) begin errors++; $display("FAIL proto_clears got=%0d expected %0d", clears, NROWS); end
    checks++;
    if (accs != NROWS * ACC) begin errors++; $display("FAIL proto_acc got=%0d expected %0d", accs, NROWS * ACC); end
    checks++;
    if (pix_err != 0) begin errors++; $display("FAIL proto_pix_line errs=%0d expected 0", pix_err); end
    checks++;
    if (row_err != 0) begin errors++; $display("FAIL proto_cmp_row errs=%0d expected 0", row_err); end
  endtask

  task automatic test_random();
    int em, ex, ey, ec;
    for (int it = 0; it < 4; it++) begin
      fill(1, 0);
      run_search(-1, int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)));
      model(em, ex, ey, ec);
      checks++;
      if (got_cyc != ec || got_mad != em || got_mvx != ex || got_mvy != ey) begin
        errors++; $display("FAIL rand%0d_res got=%0d/%0d/%0d@%0d expected %0d/%0d/%0d@%0d",
                           it, got_mad, got_mvx, got_mvy, got_cyc, em, ex, ey, ec);
      end
      checks++;
      if (post_err != 0 || hold_err != 0) begin
        errors++; $display("FAIL rand%0d_handshake post=%0d hold=%0d expected 0/0", it, post_err, hold_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_descending();
    test_tie();
    test_all_ones();
    test_delay_strays();
    test_ready_hold();
    test_protocol();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
